// File: rtl/env_ad.sv
// env_ad: trigger-driven linear attack/decay envelope generator.
// A rising edge on trig (typically a sequencer step pulse) starts or
// retriggers an envelope that ramps up to full scale, then back to zero.
// Steps advance only on ena ticks.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   ena         step-tick enable
//   trig        trigger input, rising-edge sensitive
//   attack_rate amount added per tick while attacking (sampled live)
//   decay_rate  amount subtracted per tick while decaying (sampled live)
//   env         envelope level, top OUT_W bits of the accumulator
//   active      high whenever the envelope is not idle
module env_ad #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             trig,
  input  logic [ACC_W-1:0] attack_rate,
  input  logic [ACC_W-1:0] decay_rate,
  output logic [OUT_W-1:0] env,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ATTACK = 2'd1,
    DECAY  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] MAX = '1;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             trig_q;
  logic             pend;
  logic             trig_edge;
  logic [ACC_W:0]   sum_up;
  logic             attack_done;
  logic             decay_done;

  always_comb begin
    trig_edge   = trig & ~trig_q;
    // One extra bit so an overflowing sum still compares correctly against MAX.
    sum_up      = {1'b0, acc} + {1'b0, attack_rate};
    attack_done = (attack_rate == '0) || (sum_up >= {1'b0, MAX});
    decay_done  = (decay_rate == '0) || (acc <= decay_rate);
  end

  // trig_q tracks trig even during reset so a level held high across
  // reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    trig_q <= trig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      pend  <= 1'b0;
    end else if (!ena) begin
      if (trig_edge) pend <= 1'b1;
    end else begin
      pend <= 1'b0;
      if (trig_edge || pend) begin
        // Retrigger keeps the current level and ramps up from there.
        state <= ATTACK;
      end else begin
        case (state)
          ATTACK: begin
            if (attack_done) begin
              acc   <= MAX;
              state <= DECAY;
            end else begin
              acc <= sum_up[ACC_W-1:0];
            end
          end
          DECAY: begin
            if (decay_done) begin
              acc   <= '0;
              state <= IDLE;
            end else begin
              acc <= acc - decay_rate;
            end
          end
          IDLE:    state <= IDLE;
          default: begin
            state <= IDLE;
            acc   <= '0;
          end
        endcase
      end
    end
  end

  assign env    = acc[ACC_W-1 -: OUT_W];
  assign active = (state != IDLE);

endmodule

// File: tb/tb_env_ad.sv
module tb_env_ad;

  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic             trig = 1'b0;
  logic [ACC_W-1:0] attack_rate = '0;
  logic [ACC_W-1:0] decay_rate = '0;
  logic [OUT_W-1:0] env;
  logic             active;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: level as a plain integer plus a phase
  // (0 = silent, 1 = rising, 2 = falling).
  longint m_level = 0;
  int     m_phase = 0;
  bit     m_prev_trig = 1'b0;
  bit     m_pending = 1'b0;

  env_ad #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .trig(trig),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .env(env),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit t, input bit e, input bit r,
                            input longint ar, input longint dr);
    bit rise;
    rise = t && !m_prev_trig;
    m_prev_trig = t;
    if (r) begin
      m_level = 0; m_phase = 0; m_pending = 0;
    end else if (!e) begin
      if (rise) m_pending = 1;
    end else if (rise || m_pending) begin
      m_pending = 0;
      m_phase = 1;
    end else begin
      m_pending = 0;
      if (m_phase == 1) begin
        if (ar == 0 || m_level + ar >= MAXV) begin
          m_level = MAXV; m_phase = 2;
        end else m_level = m_level + ar;
      end else if (m_phase == 2) begin
        if (dr == 0 || m_level <= dr) begin
          m_level = 0; m_phase = 0;
        end else m_level = m_level - dr;
      end
    end
  endtask

  // Apply one clock with the given inputs, then compare outputs to the model.
  task automatic tick(input bit t, input bit e, input bit r);
    trig = t; ena = e; rst = r;
    @(posedge clk);
    model_step(t, e, r, longint'(attack_rate), longint'(decay_rate));
    #1;
    check("model_env", 32'(env), 32'(m_level >> (ACC_W - OUT_W)));
    check("model_active", 32'(active), 32'(m_phase != 0));
  endtask

  task automatic run_to_idle(input string tag);
    int guard;
    guard = 0;
    while (active === 1'b1 && guard < 200) begin
      tick(1'b0, 1'b1, 1'b0);
      guard++;
    end
    check(tag, 32'(active), 32'd0);
  endtask

  logic [7:0] shape_env [6];
  logic       shape_act [6];

  initial begin
    shape_env = '{8'h40, 8'h80, 8'hC0, 8'hFF, 8'h7F, 8'h00};
    shape_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("reset_env", 32'(env), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    tick(1'b0, 1'b1, 1'b0);

    // Basic shape
    attack_rate = 24'h400000;
    decay_rate  = 24'h800000;
    tick(1'b1, 1'b1, 1'b0);
    check("start_active", 32'(active), 32'd1);
    check("start_env", 32'(env), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check($sformatf("shape_env_%0d", i), 32'(env), 32'(shape_env[i]));
      check($sformatf("shape_act_%0d", i), 32'(active), 32'(shape_act[i]));
    end

    // Sparse ena: edge with ena low is held pending
    tick(1'b1, 1'b0, 1'b0);
    check("pend_not_started", 32'(active), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("pend_still_idle", 32'(active), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    check("pend_serviced", 32'(active), 32'd1);
    check("pend_env", 32'(env), 32'd0);
    for (int i = 0; i < 40; i++) tick(1'b0, (i % 4) == 3, 1'b0);
    run_to_idle("pend_idle");

    // Retrigger mid-decay
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    check("retrig_pre", 32'(env), 32'h7F);
    tick(1'b1, 1'b1, 1'b0);
    check("retrig_active", 32'(active), 32'd1);
    check("retrig_hold", 32'(env), 32'h7F);
    tick(1'b0, 1'b1, 1'b0);
    check("retrig_env", 32'(env), 32'hBF);
    run_to_idle("retrig_idle");

    // Zero rates: instantaneous segments
    attack_rate = '0;
    decay_rate  = '0;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("zero_peak", 32'(env), 32'hFF);
    check("zero_peak_act", 32'(active), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("zero_end", 32'(env), 32'h00);
    check("zero_end_act", 32'(active), 32'd0);

    // Reset mid-attack
    attack_rate = 24'h400000;
    decay_rate  = 24'h800000;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("rst_mid_pre", 32'(env), 32'h80);
    tick(1'b0, 1'b1, 1'b1);
    check("rst_mid_env", 32'(env), 32'd0);
    check("rst_mid_act", 32'(active), 32'd0);

    // trig held high across reset release
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check("held_rst_act", 32'(active), 32'd0);
    tick(1'b1, 1'b1, 1'b0);
    check("held_rst_act2", 32'(active), 32'd0);
    tick(1'b0, 1'b1, 1'b0);

    // Held-high trig for 10 clocks gives one envelope
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
    check("held10_one_env", 32'(active), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("held10_retrig", 32'(active), 32'd1);
    run_to_idle("held10_idle");

    // Randomized traffic against the model
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0: attack_rate = 24'($urandom);
        1: attack_rate = 24'($urandom_range(0, 24'h0FFFFF));
        2: attack_rate = '0;
        default: attack_rate = 24'hFFFFFF - 24'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0: decay_rate = 24'($urandom);
        1: decay_rate = 24'($urandom_range(0, 24'h0FFFFF));
        2: decay_rate = '0;
        default: decay_rate = 24'hFFFFFF - 24'($urandom_range(0, 3));
      endcase
      for (int i = 0; i < 60; i++) begin
        tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
